// File: rtl/match_event_logger_pkg.sv
// ---------------------------------------------------------------------------
// match_log_pkg
// Shared defaults for the match event logger: stamp width, event FIFO depth,
// counter width and the derived FIFO pointer width.
// ---------------------------------------------------------------------------
package match_log_pkg;

  localparam int POS_W_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

endpackage

// File: rtl/match_event_logger_if.sv
// ---------------------------------------------------------------------------
// match_event_logger_if
// Valid/ready event stream that carries the logged match positions.
//   evt_valid : head of the event FIFO holds an event (master -> slave)
//   evt_ready : consumer accepts the head event      (slave  -> master)
//   evt_pos   : bit position of the head event       (master -> slave)
// ---------------------------------------------------------------------------
interface match_event_logger_if
  import match_log_pkg::*;
#(
  parameter int POS_W = POS_W_DEF
) ();

  logic             evt_valid;
  logic             evt_ready;
  logic [POS_W-1:0] evt_pos;

  modport master (
    output evt_valid,
    output evt_pos,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_pos,
    output evt_ready
  );

endinterface

// File: rtl/match_event_logger_fifo.sv
// ---------------------------------------------------------------------------
// match_fifo
// Small synchronous FIFO holding event positions. Read/write pointers wrap
// naturally because DEPTH is a power of two; a separate occupancy count
// tells full from empty.
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   i_push   : write request with i_data
//   i_pop    : pop the head (ignored when empty)
//   o_data   : head entry
//   o_full   : occupancy == DEPTH
//   o_empty  : occupancy == 0
// ---------------------------------------------------------------------------
module match_fifo
  import match_log_pkg::*;
#(
  parameter int W     = POS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_wr_en;
  logic w_rd_en;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // A full FIFO still takes a write when the head leaves on the same edge.
  assign w_rd_en = i_pop & ~o_empty;
  assign w_wr_en = i_push & (~o_full | w_rd_en);

  assign o_data = r_mem[r_rd_ptr];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// ---------------------------------------------------------------------------
// match_event_logger
// Stamps every detector match with the bit position at which it occurred and
// queues the stamps in a small FIFO for a downstream consumer. Keeps a
// saturating count of accepted matches and of matches lost to a full FIFO,
// plus a sticky overflow flag.
//   clk, rst    : clock, synchronous active-high reset
//   en          : bit-stream qualifier (one detector bit per en cycle)
//   match       : detector match pulse, sampled only with en=1
//   clr         : clears match_count, drop_count and overflow
//   evt         : valid/ready event stream (master side)
//   match_count : sampled matches, saturating
//   drop_count  : matches dropped on a full FIFO, saturating
//   overflow    : sticky, set by any drop
// ---------------------------------------------------------------------------
module match_event_logger
  import match_log_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 match,
  input  logic                 clr,
  match_event_logger_if.master evt,
  output logic [CNT_W-1:0]     match_count,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [POS_W-1:0] r_pos;
  logic [CNT_W-1:0] r_match_count;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_overflow;

  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [POS_W-1:0] w_head;

  assign w_push = en & match;
  assign w_pop  = ~w_empty & evt.evt_ready;
  // Only a push into a full FIFO with no simultaneous pop is lost.
  assign w_drop = w_push & w_full & ~w_pop;

  match_fifo #(
    .W     (POS_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_pos),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt.evt_valid = ~w_empty;
  // Head position is forced to zero while nothing is queued so that stale
  // storage never shows on the port.
  assign evt.evt_pos   = w_empty ? '0 : w_head;

  // Position advances with every qualified bit and wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos <= '0;
    end else if (en) begin
      r_pos <= r_pos + POS_W'(1);
    end
  end

  // clr wins over a same-cycle increment; the FIFO push is unaffected.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_match_count <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) begin
        r_match_count <= sat_inc(r_match_count);
      end
      if (w_drop) begin
        r_drop_count <= sat_inc(r_drop_count);
        r_overflow   <= 1'b1;
      end
    end
  end

  assign match_count = r_match_count;
  assign drop_count  = r_drop_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_match_event_logger.sv
module tb_match_event_logger;
  import match_log_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, match = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [7:0] match_count, drop_count;
  logic overflow;

  match_event_logger_if #(.POS_W(16)) evt_if ();
  assign evt_if.evt_ready = rdy;

  match_event_logger dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .match       (match),
    .clr         (clr),
    .evt         (evt_if.master),
    .match_count (match_count),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard / reference state
  logic [15:0] q[$];
  logic [15:0] m_pos;
  int          m_mc, m_dc;
  logic        m_ov;
  logic [15:0] last_pop;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        en, m, c, r;
    logic        valid;
    logic [15:0] pos;
    int          mc, dc;
    logic        ov;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 32'(evt_if.evt_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, "_pos"}, 32'(evt_if.evt_pos), 32'(q[0]));
    chk({tag, "_mcnt"}, 32'(match_count), 32'(m_mc));
    chk({tag, "_dcnt"}, 32'(drop_count), 32'(m_dc));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ov));
  endtask

  task automatic do_reset(input logic e, input logic m, input logic c, input logic r);
    en = e; match = m; clr = c; rdy = r; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_pos = '0; m_mc = 0; m_dc = 0; m_ov = 1'b0;
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_mcnt", 32'(match_count), 32'd0);
    chk("rst_dcnt", 32'(drop_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
  endtask

  task automatic cycle(input logic e, input logic m, input logic c, input logic r);
    logic drop;
    en = e; match = m; clr = c; rdy = r;
    if (r && q.size() != 0) last_pop = q.pop_front();
    drop = 1'b0;
    if (e && m) begin
      if (q.size() < DEPTH) q.push_back(m_pos);
      else drop = 1'b1;
    end
    if (c) begin
      m_mc = 0; m_dc = 0; m_ov = 1'b0;
    end else begin
      if (e && m && m_mc != CNT_MAX) m_mc++;
      if (drop) begin
        if (m_dc != CNT_MAX) m_dc++;
        m_ov = 1'b1;
      end
    end
    if (e) m_pos = m_pos + 16'd1;
    @(posedge clk); #1;
    check_outputs("cyc");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // en, m, clr, rdy | valid, pos, mcnt, dcnt, ovf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1, 0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 2, 0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 3, 0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 4, 0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 5, 1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 5, 1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 5, 1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 5, 1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4, 5, 1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 5, 1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 5, 1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 0, 0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd6, 1, 0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1, 0, 1'b0};

    repeat (2) @(posedge clk);
    #1;

    // Basic single match at position 5
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, (i == 5), 1'b0, 1'b0);
      if (i == 5) begin
        chk("p5_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("p5_pos", 32'(evt_if.evt_pos), 32'd5);
        chk("p5_mcnt", 32'(match_count), 32'd1);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("p5_drained", 32'(last_pop), 32'd5);

    // Table: fill, overflow, ignored match, drain, empty ready, clr
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].en, vecs[i].m, vecs[i].c, vecs[i].r);
      chk($sformatf("vec%0d_valid", i), 32'(evt_if.evt_valid), 32'(vecs[i].valid));
      if (vecs[i].valid)
        chk($sformatf("vec%0d_pos", i), 32'(evt_if.evt_pos), 32'(vecs[i].pos));
      chk($sformatf("vec%0d_mcnt", i), 32'(match_count), 32'(vecs[i].mc));
      chk($sformatf("vec%0d_dcnt", i), 32'(drop_count), 32'(vecs[i].dc));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ov));
    end

    // Full FIFO with simultaneous pop and push
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 5; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("fullpp_dcnt", 32'(drop_count), 32'd0);
    chk("fullpp_head", 32'(evt_if.evt_pos), 32'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fullpp_last", 32'(last_pop), 32'd9);

    // Position wrap
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 65536; i++) begin
      en = 1'b1;
      cycle(1'b1, (i == 65535 || i == 65536), 1'b0, 1'b0);
    end
    chk("wrap_first", 32'(evt_if.evt_pos), 32'd65535);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_second", 32'(evt_if.evt_pos), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Counter saturation and clr with a simultaneous match
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_mcnt", 32'(match_count), 32'd255);
    chk("sat_dcnt", 32'(drop_count), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_mcnt", 32'(match_count), 32'd0);
    chk("clr_dcnt", 32'(drop_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("clr_fifo%0d", i), 32'(evt_if.evt_pos), 32'(i));
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Reset mid-operation with a pending match
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst_pos", 32'(evt_if.evt_pos), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_nolog", 32'(evt_if.evt_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("midrst_pos0", 32'(evt_if.evt_pos), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 Parameter POS_W, default 16, width of the bit-position stamp.
REQ-002 Parameter DEPTH, default 4, number of event FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter CNT_W, default 8, width of the match and drop counters.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  bit-stream qualifier; the detector emits one bit per cycle in which en=1.
REQ-007 match  input  1  detector match pulse, one per detected sequence; registered detector output.
REQ-008 clr  input  1  synchronous clear of the counters and flags.
REQ-009 evt_valid  output  1  FIFO head holds an event.
REQ-010 evt_ready  input  1  consumer accepts the head event.
REQ-011 evt_pos  output  POS_W  bit position of the head event.
REQ-012 match_count  output  CNT_W  total matches accepted; saturates.
REQ-013 drop_count  output  CNT_W  matches lost to a full FIFO; saturates.
REQ-014 overflow  output  1  sticky flag: at least one match has been dropped.

Function
REQ-015 pos SHALL be an internal POS_W counter that increments by 1 on every cycle with en=1.
REQ-016 pos SHALL wrap from 2^POS_W-1 to 0 with no flag.
REQ-017 match SHALL be sampled only when en=1; match with en=0 SHALL be ignored and SHALL NOT change any count.
REQ-018 A sampled match SHALL push the pre-increment pos value of the same cycle.
REQ-019 A pushed event SHALL appear at evt_valid/evt_pos on the following cycle; latency is 1 cycle.
REQ-020 Transfer SHALL occur when evt_valid=1 and evt_ready=1; the head SHALL then pop on that edge.
REQ-021 evt_valid=1 SHALL hold, with evt_pos stable, until a transfer occurs.
REQ-022 evt_ready with an empty FIFO SHALL have no effect.
REQ-023 Ordering SHALL be FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 A full FIFO with a simultaneous pop and push SHALL accept the push; occupancy stays DEPTH.
REQ-025 A full FIFO with a push and no pop SHALL drop the new event, increment drop_count, and set overflow; the stored contents SHALL be unchanged.
REQ-026 An empty FIFO with a push SHALL go to occupancy 1; evt_valid SHALL NOT bypass the register.
REQ-027 match_count SHALL increment on every sampled match, dropped or not, and saturate at 2^CNT_W-1.
REQ-028 drop_count SHALL saturate at 2^CNT_W-1.
REQ-029 clr=1 SHALL zero match_count, drop_count and overflow.
REQ-030 clr SHALL leave the FIFO and pos untouched.
REQ-031 When clr and a sampled match occur in the same cycle, clr SHALL win for counters and flags, and the push SHALL still occur.

Reset
REQ-032 rst=1 SHALL set pos=0 and empty the FIFO (evt_valid=0).
REQ-033 rst=1 SHALL set match_count=0, drop_count=0 and overflow=0.
REQ-034 evt_pos is don't-care while evt_valid=0.
REQ-035 rst SHALL take priority over en, match, clr and evt_ready; inputs in the reset cycle SHALL be ignored.
REQ-036 Reset mid-operation SHALL discard every stored event.

Structure
REQ-037 Package match_log_pkg SHALL hold the POS_W, DEPTH and CNT_W defaults and the pointer-width constant $clog2(DEPTH).
REQ-038 Storage and pointers SHALL sit in sub-module match_fifo (push/pop/full/empty, pointer plus count).
REQ-039 The top level SHALL hold the position counter, the saturating counters and the overflow logic.

Verification
REQ-040 Reset, then en=1 for 10 cycles with match=1 only at pos 5 -> evt_valid rises the next cycle with evt_pos=5, and match_count=1.
REQ-041 evt_ready=0, matches at pos 1,2,3,4,5 -> FIFO holds 1,2,3,4; drop_count=1; overflow=1; match_count=5; draining yields 1,2,3,4 in order.
REQ-042 FIFO full, evt_ready=1 and match at pos 9 in the same cycle -> head popped, 9 accepted, drop_count unchanged.
REQ-043 en=1 for 65537 cycles with match at pos 65535 and again one cycle later -> events 65535 then 0.
REQ-044 300 matches, no drain, then clr with a simultaneous match -> match_count and drop_count saturate at 255; after clr both are 0, overflow=0, and FIFO contents are unchanged.
REQ-045 rst asserted with 3 events stored and match=1 -> next cycle evt_valid=0, all outputs 0, and the match is not logged.
